signed_sub_with_saturation_serial: RTL and testbench
====================================================

// Module: signed_sub_with_saturation_serial
//
// PURPOSE
//   Bit-serial, LSB-first signed subtractor: diff = a - b, two's complement, WIDTH bits.
//   Saturates to the most positive / most negative value on overflow.
//   Sequential counterpart of the combinational saturating adder: trades area for
//   WIDTH cycles of latency. Operands enter and the result leaves via valid/ready handshakes.
//
// PARAMETERS
//   WIDTH  4  operand and result width in bits, signed two's complement, >= 2
//
// PORTS
//   clk        in   1      clock; all state changes on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      a/b valid this cycle
//   in_ready   out  1      block can accept an operand pair
//   a          in   WIDTH  minuend, signed
//   b          in   WIDTH  subtrahend, signed
//   out_valid  out  1      diff/ovf valid
//   out_ready  in   1      downstream accepts the result
//   diff       out  WIDTH  saturated difference, signed
//   ovf        out  1      1 = true difference was out of range and diff is saturated
//
// BEHAVIOUR
//   - Reset (rst=1 at an edge): state IDLE, in_ready=1, out_valid=0, diff=0, ovf=0, bit counter=0.
//     Reset has priority over every other event and aborts any in-flight operation
//     (captured operands and partial result are discarded, no output is produced).
//   - FSM states: IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: in_ready=1. in_valid=1 at an edge: capture a, b into shift registers, carry=1
//     (subtract as a + ~b + 1), counter=0, go to BUSY. in_valid=0: stay in IDLE.
//   - BUSY: in_ready=0. One bit per edge, LSB first: s = a_i ^ ~b_i ^ c, c' = majority(a_i, ~b_i, c).
//     Shift s into the result register MSB side. Exactly WIDTH edges in BUSY.
//     On the WIDTH-th edge, saturate and move to DONE.
//   - Overflow rule: ovf = (a_msb != b_msb) & (raw_msb != a_msb), using the captured operand MSBs.
//     If ovf and a_msb=1: diff = 1 followed by WIDTH-1 zeros (most negative).
//     If ovf and a_msb=0: diff = 0 followed by WIDTH-1 ones (most positive).
//     Otherwise diff = raw WIDTH-bit result.
//   - DONE: out_valid=1. diff/ovf stay stable while out_valid=1 and out_ready=0 (no limit on the stall).
//     out_ready=1 at an edge: out_valid=0, go to IDLE. diff/ovf keep their last value until the next DONE.
//   - Latency: the accept edge is edge 0. out_valid rises after edge WIDTH.
//     With out_ready held at 1, in_ready returns after edge WIDTH+1.
//     Throughput is 1 operation per WIDTH+2 cycles.
//   - in_valid, a and b are ignored outside IDLE. Changes to a/b after the accept edge have no effect.
//   - out_ready is ignored outside DONE. in_ready and out_valid are never 1 at the same time.
//   - Boundary cases:
//     - a == b gives 0 with ovf=0.
//     - min - min gives 0 with ovf=0.
//     - 0 - min overflows and gives max with ovf=1.
//     - min - 1 gives min with ovf=1.
//     - max - (-1) gives max with ovf=1.
//
// TESTING   (WIDTH=4, decimal signed)
//   1. a=3,b=5 -> diff=-2 ovf=0; a=-1,b=2 -> -3 ovf=0. out_valid rises exactly 4 edges after accept.
//   2. a=3,b=-5 -> 7 ovf=1; a=-4,b=7 -> -8 ovf=1; a=0,b=-8 -> 7 ovf=1; a=-8,b=1 -> -8 ovf=1.
//   3. a=-8,b=-8 -> 0 ovf=0; a=7,b=7 -> 0 ovf=0; a=7,b=-1 -> 7 ovf=1.
//   4. out_ready=0 for 10 cycles in DONE -> out_valid=1 and diff/ovf stable throughout.
//      in_valid pulses with new a/b during BUSY and DONE are ignored.
//   5. rst=1 on the 2nd BUSY edge -> next cycle IDLE, in_ready=1, out_valid=0, diff=0.
//      The next operation (a=1,b=1) returns 0.
//   6. Exhaustive sweep of all 256 a/b pairs with a random out_ready stall.
//      Compare against a reference model: clamp(a-b, -8, 7), with ovf = (a-b out of range).

Source files
------------

// File: rtl/signed_sub_with_saturation_serial_if.sv
// Operand/result handshake bundle for the bit-serial saturating subtractor.
// The master side drives operands and consumes results; the slave side is the subtractor.
interface signed_sub_with_saturation_serial_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, ovf
    );
endinterface

// File: rtl/signed_sub_with_saturation_serial.sv
// Bit-serial LSB-first signed subtractor (a - b) with saturation on overflow.
// Takes WIDTH cycles per operation plus one accept and one handoff cycle.
module signed_sub_with_saturation_serial #(
    parameter int unsigned WIDTH = 4
) (
    input logic                              clk,
    input logic                              rst,
    signed_sub_with_saturation_serial_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] res_q, res_n;
    logic [WIDTH-1:0] diff_q, diff_n;
    logic             carry_q, carry_n;
    logic             a_msb_q, a_msb_n;
    logic             b_msb_q, b_msb_n;
    logic             ovf_q, ovf_n;
    logic             in_ready_q, in_ready_n;
    logic             out_valid_q, out_valid_n;

    logic             a_bit, nb_bit, sum_bit, sat;
    logic [WIDTH-1:0] raw;

    // State and datapath registers; reset aborts any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            diff_q      <= '0;
            carry_q     <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            a_q         <= a_n;
            b_q         <= b_n;
            res_q       <= res_n;
            diff_q      <= diff_n;
            carry_q     <= carry_n;
            a_msb_q     <= a_msb_n;
            b_msb_q     <= b_msb_n;
            ovf_q       <= ovf_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
        end
    end

    // Next-state, one full-adder slice of a + ~b + 1, and saturation
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        a_n         = a_q;
        b_n         = b_q;
        res_n       = res_q;
        diff_n      = diff_q;
        carry_n     = carry_q;
        a_msb_n     = a_msb_q;
        b_msb_n     = b_msb_q;
        ovf_n       = ovf_q;
        in_ready_n  = in_ready_q;
        out_valid_n = out_valid_q;

        a_bit   = a_q[0];
        nb_bit  = ~b_q[0];
        sum_bit = a_bit ^ nb_bit ^ carry_q;
        raw     = {sum_bit, res_q[WIDTH-1:1]};
        sat     = (a_msb_q != b_msb_q) && (sum_bit != a_msb_q);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_n        = bus.a;
                    b_n        = bus.b;
                    a_msb_n    = bus.a[WIDTH-1];
                    b_msb_n    = bus.b[WIDTH-1];
                    carry_n    = 1'b1;
                    cnt_n      = '0;
                    in_ready_n = 1'b0;
                    state_n    = BUSY;
                end
            end
            BUSY: begin
                a_n     = {1'b0, a_q[WIDTH-1:1]};
                b_n     = {1'b0, b_q[WIDTH-1:1]};
                carry_n = (a_bit & nb_bit) | (a_bit & carry_q) | (nb_bit & carry_q);
                res_n   = raw;
                cnt_n   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    ovf_n       = sat;
                    diff_n      = sat ? (a_msb_q ? SAT_MIN : SAT_MAX) : raw;
                    out_valid_n = 1'b1;
                    state_n     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_n = 1'b0;
                    in_ready_n  = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: begin
                out_valid_n = 1'b0;
                in_ready_n  = 1'b1;
                state_n     = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_signed_sub_with_saturation_serial.sv
// Self-checking bench: directed boundary cases, stall/ignore/reset scenarios,
// exhaustive sweep and random pairs against a clamp(a-b) reference model.
module tb_signed_sub_with_saturation_serial;
    localparam int unsigned W = 4;
    localparam int MAXV = (1 << (W - 1)) - 1;
    localparam int MINV = -(1 << (W - 1));

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    signed_sub_with_saturation_serial_if #(.WIDTH(W)) bus ();

    signed_sub_with_saturation_serial #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: true difference clamped to the signed W-bit range
    function automatic void ref_model(input int sa, input int sb, output int d, output bit o);
        int r;
        r = sa - sb;
        o = (r > MAXV) || (r < MINV);
        d = (r > MAXV) ? MAXV : ((r < MINV) ? MINV : r);
    endfunction

    task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input int stall, input bit glitch, input string tag);
        int             exp_d;
        bit             exp_o;
        logic [W-1:0]   exp_bits;
        logic [W-1:0]   held_d;
        logic           held_o;
        int             lat;
        bit             seen;
        ref_model(int'($signed(ai)), int'($signed(bi)), exp_d, exp_o);
        exp_bits = W'(exp_d);

        bus.out_ready = (stall == 0);
        bus.in_valid  = 1'b1;
        bus.a         = ai;
        bus.b         = bi;
        @(posedge clk);
        @(negedge clk);
        if (glitch) begin
            bus.a = W'($urandom);
            bus.b = W'($urandom);
        end else begin
            bus.in_valid = 1'b0;
        end
        check({tag, ":in_ready_busy"}, int'(bus.in_ready), 0);

        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            seen = bus.out_valid;
            if (glitch) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
            end
        end
        check({tag, ":latency"}, lat, int'(W));
        if (!seen) begin
            bus.in_valid = 1'b0;
            return;
        end
        check({tag, ":diff"}, int'(bus.diff), int'(exp_bits));
        check({tag, ":ovf"}, int'(bus.ovf), int'(exp_o));
        held_d = bus.diff;
        held_o = bus.ovf;

        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, ":stall_valid"}, int'(bus.out_valid), 1);
            check({tag, ":stall_diff"}, int'(bus.diff), int'(held_d));
            check({tag, ":stall_ovf"}, int'(bus.ovf), int'(held_o));
            check({tag, ":stall_in_ready"}, int'(bus.in_ready), 0);
        end

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ":out_valid_drop"}, int'(bus.out_valid), 0);
        check({tag, ":in_ready_back"}, int'(bus.in_ready), 1);
        check({tag, ":diff_hold"}, int'(bus.diff), int'(exp_bits));
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", int'(bus.in_ready), 1);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_diff", int'(bus.diff), 0);
        check("reset_ovf", int'(bus.ovf), 0);

        // Directed: normal, overflow and boundary cases (decimal signed, W=4)
        do_op(4'd3,  4'd5,  0, 1'b0, "3-5");
        do_op(4'hF,  4'd2,  0, 1'b0, "-1-2");
        do_op(4'd3,  4'hB,  0, 1'b0, "3-(-5)");
        do_op(4'hC,  4'd7,  0, 1'b0, "-4-7");
        do_op(4'd0,  4'h8,  0, 1'b0, "0-min");
        do_op(4'h8,  4'd1,  0, 1'b0, "min-1");
        do_op(4'h8,  4'h8,  0, 1'b0, "min-min");
        do_op(4'd7,  4'd7,  0, 1'b0, "7-7");
        do_op(4'd7,  4'hF,  0, 1'b0, "max-(-1)");

        // Long output stall with in_valid noise during BUSY and DONE
        do_op(4'd3,  4'd5,  10, 1'b1, "stall");

        // Reset asserted on the second BUSY edge aborts the operation
        bus.in_valid = 1'b1;
        bus.a        = 4'd5;
        bus.b        = 4'd2;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", int'(bus.in_ready), 1);
        check("abort_out_valid", int'(bus.out_valid), 0);
        check("abort_diff", int'(bus.diff), 0);
        check("abort_ovf", int'(bus.ovf), 0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("abort_no_output", int'(bus.out_valid), 0);
        do_op(4'd1, 4'd1, 0, 1'b0, "after_abort");

        // Exhaustive sweep with random output stalls and input noise
        for (int ai = 0; ai < (1 << W); ai++) begin
            for (int bi = 0; bi < (1 << W); bi++) begin
                do_op(W'(ai), W'(bi), int'($urandom_range(0, 3)), 1'($urandom), "sweep");
            end
        end

        // Additional random pairs
        for (int k = 0; k < 50; k++) begin
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 5)), 1'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
